// File: rtl/gcd_client.sv
// Request/result driver for the 16-bit GCD engine with an in-order response FIFO.
// Optional per-response cycle counts are enabled with `define GCD_CLIENT_CYCLES_EN.
module gcd_client #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        gcd_in_valid,
    input  logic        gcd_in_ready,
    output logic [31:0] gcd_in_data,
    input  logic        gcd_out_valid,
    input  logic [15:0] gcd_out_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        busy,
`ifdef GCD_CLIENT_CYCLES_EN
    output logic [15:0] resp_cycles,
`endif
    output logic        proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t       state_q, state_d;
    logic [31:0]  in_data_q;
    logic [15:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]  count_q;
    logic         err_q;

    logic         req_ready_s;
    logic         req_fire_s;
    logic         bypass_s;
    logic         issue_s;
    logic         res_push_s;
    logic         push_s;
    logic         pop_s;
    logic [15:0]  push_data_s;

    // Space for the single outstanding operation is reserved at acceptance,
    // so a result push can never find the FIFO full.
    assign req_ready_s = !reset && (state_q == IDLE) && (count_q < DEPTH_C);
    assign req_fire_s  = req_valid && req_ready_s;
    assign bypass_s    = req_fire_s && (req_b == 16'd0);
    assign issue_s     = req_fire_s && (req_b != 16'd0);
    assign res_push_s  = (state_q == WAIT) && gcd_out_valid;
    assign push_s      = bypass_s || res_push_s;
    assign push_data_s = bypass_s ? req_a : gcd_out_data;
    assign pop_s       = (count_q != '0) && resp_ready;

    // Next-state logic for the request sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue_s) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (gcd_in_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (gcd_out_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request holding register, FIFO storage/pointers and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            in_data_q <= 32'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'd0;
            end
        end else begin
            state_q <= state_d;
            if (issue_s) begin
                in_data_q <= {req_a, req_b};
            end
            if (push_s) begin
                mem_q[wr_ptr_q] <= push_data_s;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            // A result outside WAIT is dropped and latched as a violation.
            if (gcd_out_valid && (state_q != WAIT)) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef GCD_CLIENT_CYCLES_EN
    logic [15:0] cyc_q;
    logic [15:0] cyc_next_s;
    logic [15:0] cmem_q [DEPTH];

    // The counter is primed to 1 on acceptance so the stored value includes
    // both the ISSUE-entry edge and the result edge.
    assign cyc_next_s = (cyc_q == 16'hFFFF) ? 16'hFFFF : cyc_q + 16'd1;

    // Operation cycle counter and its per-entry storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                cmem_q[i] <= 16'd0;
            end
        end else begin
            if (issue_s) begin
                cyc_q <= 16'd1;
            end else if (state_q != IDLE) begin
                cyc_q <= cyc_next_s;
            end
            if (push_s) begin
                cmem_q[wr_ptr_q] <= bypass_s ? 16'd0 : cyc_next_s;
            end
        end
    end

    assign resp_cycles = cmem_q[rd_ptr_q];
`endif

    assign req_ready    = req_ready_s;
    assign gcd_in_valid = (state_q == ISSUE);
    assign gcd_in_data  = in_data_q;
    assign resp_valid   = (count_q != '0);
    assign resp_data    = mem_q[rd_ptr_q];
    assign busy         = (state_q != IDLE);
    assign proto_err    = err_q;

endmodule

// File: tb/tb_gcd_client.sv
// Directed testbench for gcd_client with a small behavioural GCD engine attached.
module tb_gcd_client;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        gcd_in_valid;
    logic        gcd_in_ready;
    logic [31:0] gcd_in_data;
    logic        gcd_out_valid;
    logic [15:0] gcd_out_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        busy;
    logic        proto_err;
`ifdef GCD_CLIENT_CYCLES_EN
    logic [15:0] resp_cycles;
`endif

    int checks = 0;
    int failures = 0;

    logic        stall;
    int          spur_cnt;
    int          spur_seen;
    logic        eng_busy;
    int          eng_delay;
    logic [15:0] eng_res;

    gcd_client #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .gcd_in_valid(gcd_in_valid), .gcd_in_ready(gcd_in_ready), .gcd_in_data(gcd_in_data),
        .gcd_out_valid(gcd_out_valid), .gcd_out_data(gcd_out_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy),
`ifdef GCD_CLIENT_CYCLES_EN
        .resp_cycles(resp_cycles),
`endif
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] euclid(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a;
        y = b;
        for (int i = 0; i < 64; i++) begin
            if (y != 16'd0) begin
                t = x % y;
                x = y;
                y = t;
            end
        end
        return x;
    endfunction

    // Engine model: accepts when idle, answers with a one-cycle pulse a few cycles later.
    assign gcd_in_ready = !eng_busy && !stall;
    always @(posedge clk) begin
        if (reset && !gcd_in_valid && (spur_cnt == spur_seen)) begin
            gcd_out_valid <= 1'b0;
        end
        gcd_out_valid <= 1'b0;
        if (spur_cnt != spur_seen) begin
            spur_seen     <= spur_cnt;
            gcd_out_valid <= 1'b1;
            gcd_out_data  <= 16'hDEAD;
        end else if (eng_busy) begin
            if (eng_delay == 0) begin
                gcd_out_valid <= 1'b1;
                gcd_out_data  <= eng_res;
                eng_busy      <= 1'b0;
            end else begin
                eng_delay <= eng_delay - 1;
            end
        end else if (gcd_in_valid && gcd_in_ready) begin
            eng_busy  <= 1'b1;
            eng_delay <= 2;
            eng_res   <= euclid(gcd_in_data[31:16], gcd_in_data[15:0]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge and return at the falling edge after acceptance.
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("send_timeout", 32'(req_ready), 32'd1);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [15:0] exp);
        int n;
        n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check(tag, 32'(resp_data), 32'(exp));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_a      = 16'd0;
        req_b      = 16'd0;
        resp_ready = 1'b0;
        stall      = 1'b0;
        spur_cnt   = 0;
        spur_seen  = 0;
        eng_busy   = 1'b0;
        eng_delay  = 0;
        eng_res    = 16'd0;
        gcd_out_valid = 1'b0;
        gcd_out_data  = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_in_valid", 32'(gcd_in_valid), 32'd0);
        check("rst_in_data", gcd_in_data, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Basic operation gcd(48,18) = 6.
        send(16'd48, 16'd18);
        check("basic_in_valid", 32'(gcd_in_valid), 32'd1);
        check("basic_in_data", gcd_in_data, 32'h0030_0012);
        check("basic_busy", 32'(busy), 32'd1);
        pop_check("basic_data", 16'd6);
        check("basic_busy_done", 32'(busy), 32'd0);
        check("basic_proto_err", 32'(proto_err), 32'd0);

        // Bypass: b == 0 returns a directly, next cycle, without the engine.
        send(16'h0025, 16'd0);
        check("byp_resp_valid", 32'(resp_valid), 32'd1);
        check("byp_resp_data", 32'(resp_data), 32'h25);
        check("byp_in_valid", 32'(gcd_in_valid), 32'd0);
        check("byp_busy", 32'(busy), 32'd0);
        pop_check("byp_pop", 16'h0025);
        send(16'd0, 16'd0);
        pop_check("byp_zero", 16'd0);

        // Fill the FIFO with resp_ready low.
        send(16'd12, 16'd8);
        send(16'd9, 16'd6);
        send(16'd7, 16'd0);
        send(16'd100, 16'd75);
        for (int i = 0; i < 20; i++) begin
            if (busy || !dut.resp_valid) @(negedge clk);
        end
        @(negedge clk);
        check("full_busy", 32'(busy), 32'd0);
        check("full_req_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_a     = 16'd33;
        req_b     = 16'd11;
        repeat (3) @(negedge clk);
        check("full_held_ready", 32'(req_ready), 32'd0);
        check("full_held_issue", 32'(gcd_in_valid), 32'd0);
        resp_ready = 1'b1;
        check("drain0", 32'(resp_data), 32'd4);
        @(negedge clk);
        check("drain1", 32'(resp_data), 32'd3);
        check("drain1_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("fifth_accepted", 32'(gcd_in_valid), 32'd1);
        check("fifth_data", gcd_in_data, 32'h0021_000B);
        check("drain2", 32'(resp_data), 32'd7);
        @(negedge clk);
        check("drain3", 32'(resp_data), 32'd25);
        @(negedge clk);
        resp_ready = 1'b0;
        check("drained_empty", 32'(resp_valid), 32'd0);
        pop_check("fifth_result", 16'd11);

        // Push/pop in one cycle across the pointer wrap.
        send(16'd1, 16'd0);
        send(16'd2, 16'd0);
        send(16'd3, 16'd0);
        pop_check("wrap_p1", 16'd1);
        pop_check("wrap_p2", 16'd2);
        send(16'd4, 16'd0);
        req_valid  = 1'b1;
        req_a      = 16'd5;
        req_b      = 16'd0;
        resp_ready = 1'b1;
        check("pp_req_ready", 32'(req_ready), 32'd1);
        check("pp_head", 32'(resp_data), 32'd3);
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        pop_check("wrap_p4", 16'd4);
        pop_check("wrap_p5", 16'd5);
        check("wrap_empty", 32'(resp_valid), 32'd0);

        // Engine stall for 5 cycles in ISSUE.
        stall = 1'b1;
        send(16'd48, 16'd18);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(gcd_in_valid), 32'd1);
            check("stall_data", gcd_in_data, 32'h0030_0012);
            @(negedge clk);
        end
        stall = 1'b0;
        check("stall_valid6", 32'(gcd_in_valid), 32'd1);
        @(negedge clk);
        check("stall_handshake", 32'(gcd_in_valid), 32'd0);
        check("stall_wait_busy", 32'(busy), 32'd1);
        pop_check("stall_result", 16'd6);

        // Spurious result in IDLE.
        check("pre_spur_err", 32'(proto_err), 32'd0);
        spur_cnt = 1;
        repeat (2) @(negedge clk);
        check("spur_err", 32'(proto_err), 32'd1);
        check("spur_dropped", 32'(resp_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("spur_sticky", 32'(proto_err), 32'd1);

        // Asynchronous reset in WAIT.
        send(16'd9, 16'd6);
        @(negedge clk);
        check("rw_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_err", 32'(proto_err), 32'd0);
        check("arst_in_valid", 32'(gcd_in_valid), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_empty", 32'(resp_valid), 32'd0);
        check("post_rst_err", 32'(proto_err), 32'd0);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        send(16'd100, 16'd75);
        pop_check("post_rst_op", 16'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
